// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational alu between two
// requesters, with registered operands and a registered result.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [CTRLW-1:0] req_op0,
  input  logic [CTRLW-1:0] req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [CTRLW-1:0] alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t next_state;
  logic   last_grant;
  logic   owner;
  logic   gnt;
  logic   take;
  logic   done;

  assign gnt  = req_ready[1];
  assign take = (state == IDLE) && |(req_valid & req_ready);
  assign done = (state == RESP) && resp_ready[owner];
  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and round-robin ready; contention goes to the
  // requester that was not served last.
  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    unique case (state)
      IDLE: begin
        if (req_valid == 2'b11) begin
          req_ready = last_grant ? 2'b01 : 2'b10;
        end else begin
          req_ready = req_valid;
        end
        if (|(req_valid & req_ready)) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (resp_ready[owner]) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture on grant, result capture after the alu settles,
  // and response release on the owner's handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_srca    <= '0;
      alu_srcb    <= '0;
      alu_ctrl    <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (take) begin
        alu_srca   <= gnt ? req_a1 : req_a0;
        alu_srcb   <= gnt ? req_b1 : req_b0;
        alu_ctrl   <= gnt ? req_op1 : req_op0;
        owner      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_valid  <= owner ? 2'b10 : 2'b01;
      end
      if (done) begin
        resp_valid <= 2'b00;
      end
    end
  end

endmodule
